ps2_packet_rx: RTL and testbench

Parametrised PS/2 mouse packet receiver that samples the device clock and data lines, deframes 11-bit PS/2 characters, checks start, stop and parity, and assembles multi-byte mouse packets. It is the successor to the fixed 3-byte, counter-paced mouse capture logic. It presents completed packets through a valid/ready holding register, together with decoded buttons and sign-extended X/Y deltas. It sits between the board PS/2 pins and the display/cursor logic.

---
 rtl/ps2_packet_rx.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_packet_rx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_packet_rx.sv
// PS/2 mouse packet receiver: synchronises pins, deframes characters, assembles packets.
// Define PS2_PARITY_CHECK_EN to reject bytes with bad odd parity.
module ps2_packet_rx #(
    parameter int PACKET_BYTES   = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ps2_clk,
    input  logic                      ps2_data,
    input  logic                      pkt_ready,
    output logic                      pkt_valid,
    output logic [8*PACKET_BYTES-1:0] pkt_data,
    output logic [2:0]                btn,
    output logic [8:0]                dx,
    output logic [8:0]                dy,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      overrun
);

    localparam int W  = 8 * PACKET_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(PACKET_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;

    state_t         state, state_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shift, shift_n;
    logic [IW-1:0]  idx, idx_n;
    logic [W-1:0]   asm_buf, asm_buf_n;
    logic [TW-1:0]  tmo, tmo_n;
    logic           done;
    logic           ferr_n;
    logic           busy;

`ifdef PS2_PARITY_CHECK_EN
    logic           par_bit, par_bit_n;
    logic           perr_n;
`endif

    // Synchronise both pins and remember the previous clock level for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];
    assign busy   = (state != IDLE) || (idx != '0);

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            idx     <= '0;
            asm_buf <= '0;
            tmo     <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            idx     <= idx_n;
            asm_buf <= asm_buf_n;
            tmo     <= tmo_n;
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= par_bit_n;
`endif
        end
    end

    // Bit deframing, byte assembly and idle timeout
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        idx_n     = idx;
        asm_buf_n = asm_buf;
        done      = 1'b0;
        ferr_n    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_bit_n = par_bit;
        perr_n    = 1'b0;
`endif
        if (fall) begin
            tmo_n = '0;
        end else if (tmo != TW'(TIMEOUT_CYCLES)) begin
            tmo_n = tmo + TW'(1);
        end else begin
            tmo_n = tmo;
        end

        if (fall) begin
            case (state)
                IDLE: begin
                    if (!bit_in) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shift_n   = {bit_in, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_bit_n = bit_in;
`endif
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    if (!bit_in) begin
                        ferr_n = 1'b1;
                        idx_n  = '0;
`ifdef PS2_PARITY_CHECK_EN
                    end else if (!(^{shift, par_bit})) begin
                        perr_n = 1'b1;
                        idx_n  = '0;
`endif
                    end else if (idx == '0 && !shift[3]) begin
                        ferr_n = 1'b1;
                    end else begin
                        for (int i = 0; i < PACKET_BYTES; i++) begin
                            if (idx == IW'(i)) begin
                                asm_buf_n[8*i +: 8] = shift;
                            end
                        end
                        if (idx == IW'(PACKET_BYTES - 1)) begin
                            done  = 1'b1;
                            idx_n = '0;
                        end else begin
                            idx_n = idx + IW'(1);
                        end
                    end
                end
            endcase
        end else if (busy && tmo == TW'(TIMEOUT_CYCLES)) begin
            state_n = IDLE;
            idx_n   = '0;
            ferr_n  = 1'b1;
            tmo_n   = '0;
        end
    end

    // Packet holding register with valid/ready handshake and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            btn       <= '0;
            dx        <= '0;
            dy        <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_n;
            overrun   <= 1'b0;
            if (done) begin
                if (!pkt_valid || pkt_ready) begin
                    pkt_valid <= 1'b1;
                    pkt_data  <= asm_buf_n;
                    btn       <= asm_buf_n[2:0];
                    dx        <= {asm_buf_n[4], asm_buf_n[15:8]};
                    dy        <= {asm_buf_n[5], asm_buf_n[23:16]};
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pkt_ready) begin
                pkt_valid <= 1'b0;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    // Parity failure pulse, aligned with the other error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Scoreboard bench for ps2_packet_rx: 3-byte and 4-byte instances,
// byte-level reference model, decoupled packet monitors.
module tb_ps2_packet_rx;

    localparam int H   = 20;
    localparam int TMO = 600;
    localparam int SY  = 2;
    localparam bit PCHK =
`ifdef PS2_PARITY_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pc[2]  = '{1'b1, 1'b1};
    logic pd[2]  = '{1'b1, 1'b1};
    logic rdy[2] = '{1'b1, 1'b1};

    logic        v0, fe0, pe0, ov0;
    logic [23:0] data0;
    logic [2:0]  btn0;
    logic [8:0]  dx0, dy0;
    logic        v1, fe1, pe1, ov1;
    logic [31:0] data1;
    logic [2:0]  btn1;
    logic [8:0]  dx1, dy1;

    always #5 clk = ~clk;

    ps2_packet_rx #(.PACKET_BYTES(3), .SYNC_STAGES(SY), .TIMEOUT_CYCLES(TMO)) dut0 (
        .clk(clk), .rst(rst), .ps2_clk(pc[0]), .ps2_data(pd[0]),
        .pkt_ready(rdy[0]), .pkt_valid(v0), .pkt_data(data0), .btn(btn0),
        .dx(dx0), .dy(dy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
    );

    ps2_packet_rx #(.PACKET_BYTES(4), .SYNC_STAGES(SY), .TIMEOUT_CYCLES(TMO)) dut1 (
        .clk(clk), .rst(rst), .ps2_clk(pc[1]), .ps2_data(pd[1]),
        .pkt_ready(rdy[1]), .pkt_valid(v1), .pkt_data(data1), .btn(btn1),
        .dx(dx1), .dy(dy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] expq0[$];
    logic [31:0] expq1[$];
    logic [7:0]  part[2][4];
    int          np[2] = '{0, 0};
    int          pb[2] = '{3, 4};
    int          ef[2] = '{0, 0};
    int          ep[2] = '{0, 0};
    int          eo[2] = '{0, 0};
    bit          mv[2] = '{1'b0, 1'b0};

    // Observed error pulses
    int gf[2] = '{0, 0};
    int gp[2] = '{0, 0};
    int go[2] = '{0, 0};

    function automatic void model_byte(int d, logic [7:0] b, bit badp, bit bads, bit coin);
        logic [31:0] pkt;
        if (bads) begin
            ef[d]++;
            np[d] = 0;
            return;
        end
        if (badp && PCHK) begin
            ep[d]++;
            np[d] = 0;
            return;
        end
        if (np[d] == 0 && !b[3]) begin
            ef[d]++;
            return;
        end
        part[d][np[d]] = b;
        np[d]++;
        if (np[d] == pb[d]) begin
            pkt = '0;
            for (int i = 0; i < pb[d]; i++) pkt[8*i +: 8] = part[d][i];
            np[d] = 0;
            if (mv[d] && !coin) begin
                eo[d]++;
            end else begin
                if (d == 0) expq0.push_back(pkt);
                else expq1.push_back(pkt);
                mv[d] = !rdy[d];
            end
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int d, input logic v, input bit coin);
        pd[d] = v;
        tick(H);
        pc[d] = 1'b0;
        if (coin) begin
            tick(SY);
            rdy[d] = 1'b1;
            tick(1);
            rdy[d] = 1'b0;
            chk("coincide_valid", 32'(d == 0 ? v0 : v1), 32'd1);
            chk("coincide_no_ovr", 32'(d == 0 ? ov0 : ov1), 32'd0);
            tick(H - SY - 1);
        end else begin
            tick(H);
        end
        pc[d] = 1'b1;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input bit badp,
                             input bit bads, input bit coin);
        logic p;
        model_byte(d, b, badp, bads, coin);
        p = ~(^b);
        if (badp) p = ~p;
        send_bit(d, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d, b[i], 1'b0);
        send_bit(d, p, 1'b0);
        send_bit(d, !bads, coin);
        pd[d] = 1'b1;
        tick(2 * H);
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(0, a, 0, 0, 0);
        send_byte(0, b, 0, 0, 0);
        send_byte(0, c, 0, 0, 0);
    endtask

    task automatic settle(input int d, input string tag);
        tick(TMO + 50);
        if (np[d] != 0) begin
            ef[d]++;
            np[d] = 0;
        end
        chk({tag, "_frame_err"}, 32'(gf[d]), 32'(ef[d]));
        chk({tag, "_parity_err"}, 32'(gp[d]), 32'(ep[d]));
        chk({tag, "_overrun"}, 32'(go[d]), 32'(eo[d]));
    endtask

    // Monitor: count error pulses and check accepted packets for the 3-byte unit
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (fe0) gf[0]++;
            if (pe0) gp[0]++;
            if (ov0) go[0]++;
            if (v0 && rdy[0]) begin
                if (expq0.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pkt0_unexpected: got %h expected none", data0);
                end else begin
                    e = expq0.pop_front();
                    chk("pkt0_data", 32'(data0), e & 32'h00FF_FFFF);
                    chk("pkt0_btn", 32'(btn0), 32'(e[2:0]));
                    chk("pkt0_dx", 32'(dx0), 32'({e[4], e[15:8]}));
                    chk("pkt0_dy", 32'(dy0), 32'({e[5], e[23:16]}));
                end
            end
        end
    end

    // Monitor: same for the 4-byte wheel unit
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (fe1) gf[1]++;
            if (pe1) gp[1]++;
            if (ov1) go[1]++;
            if (v1 && rdy[1]) begin
                if (expq1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pkt1_unexpected: got %h expected none", data1);
                end else begin
                    e = expq1.pop_front();
                    chk("pkt1_data", data1, e);
                    chk("pkt1_btn", 32'(btn1), 32'(e[2:0]));
                    chk("pkt1_dx", 32'(dx1), 32'({e[4], e[15:8]}));
                    chk("pkt1_dy", 32'(dy1), 32'({e[5], e[23:16]}));
                end
            end
        end
    end

    initial begin
        logic [7:0] r0, r1, r2, r3;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        chk("rst_valid0", 32'(v0), 0);
        chk("rst_data0", 32'(data0), 0);
        chk("rst_btn0", 32'(btn0), 0);
        chk("rst_dx0", 32'(dx0), 0);
        chk("rst_dy0", 32'(dy0), 0);
        chk("rst_errs0", 32'({fe0, pe0, ov0}), 0);
        chk("rst_valid1", 32'(v1), 0);
        chk("rst_data1", data1, 0);
        chk("rst_errs1", 32'({fe1, pe1, ov1}), 0);
        tick(30);
        chk("idle_valid0", 32'(v0), 0);
        chk("idle_valid1", 32'(v1), 0);

        send3(8'h29, 8'h05, 8'hFB);
        settle(0, "nominal");

        send_byte(0, 8'h01, 0, 0, 0);
        send3(8'h08, 8'h00, 8'h00);
        settle(0, "resync");

        send_byte(0, 8'h09, 0, 0, 0);
        send_byte(0, 8'h5A, 1, 0, 0);
        send_byte(0, 8'h00, 0, 0, 0);
        settle(0, "parity");
        send3(8'h0A, 8'h12, 8'h34);
        settle(0, "after_parity");

        send_byte(0, 8'h08, 0, 0, 0);
        send_byte(0, 8'h11, 0, 1, 0);
        send3(8'h08, 8'h22, 8'h33);
        settle(0, "stop_bit");

        for (int k = 0; k < 8; k++) begin
            r0 = 8'($urandom) | 8'h08;
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            send_byte(0, r0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, 0);
            send_byte(0, r1, $urandom_range(0, 7) == 0, 0, 0);
            send_byte(0, r2, 0, 0, 0);
        end
        settle(0, "random3");

        rdy[0] = 1'b0;
        send3(8'h19, 8'h40, 8'hC0);
        tick(5);
        chk("hold_valid", 32'(v0), 1);
        send3(8'h0C, 8'h77, 8'h66);
        tick(5);
        chk("retain_data", 32'(data0), 32'h00C0_4019);
        send_byte(0, 8'h2B, 0, 0, 0);
        send_byte(0, 8'h80, 0, 0, 0);
        send_byte(0, 8'h01, 0, 0, 1);
        tick(5);
        chk("third_held", 32'(data0), 32'h0001_802B);
        rdy[0] = 1'b1;
        mv[0] = 1'b0;
        settle(0, "overrun");
        chk("drained_valid", 32'(v0), 0);

        send_byte(1, 8'h08, 0, 0, 0);
        send_byte(1, 8'h01, 0, 0, 0);
        settle(1, "timeout");
        send_byte(1, 8'h18, 0, 0, 0);
        send_byte(1, 8'hFE, 0, 0, 0);
        send_byte(1, 8'h03, 0, 0, 0);
        send_byte(1, 8'h7F, 0, 0, 0);
        settle(1, "wheel");
        for (int k = 0; k < 4; k++) begin
            r0 = 8'($urandom) | 8'h08;
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r3 = 8'($urandom);
            send_byte(1, r0, 0, 0, 0);
            send_byte(1, r1, $urandom_range(0, 7) == 0, 0, 0);
            send_byte(1, r2, 0, 0, 0);
            send_byte(1, r3, 0, 0, 0);
        end
        settle(1, "random4");

        chk("queue0_empty", 32'(expq0.size()), 0);
        chk("queue1_empty", 32'(expq1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
